// File: rtl/alu_arbiter_pkg.sv
// Shared ALU constants and opcode encodings for the arbitrated ALU slice,
// plus the output-slot state type.
package alu_arbiter_pkg;

  localparam int ALU_OPCODE_WIDTH = 4;
  localparam int XPR_LEN          = 32;
  localparam int SHAMT_WIDTH      = 5;

  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OP_ADD  = 4'd0;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OP_SLL  = 4'd1;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OP_XOR  = 4'd2;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OP_OR   = 4'd3;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OP_AND  = 4'd4;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OP_SRL  = 4'd5;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OP_SEQ  = 4'd6;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OP_SNE  = 4'd7;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OP_SUB  = 4'd8;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OP_SRA  = 4'd9;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OP_SLT  = 4'd10;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OP_SGE  = 4'd11;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OP_SLTU = 4'd12;
  localparam logic [ALU_OPCODE_WIDTH-1:0] ALU_OP_SGEU = 4'd13;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/alu.sv
// Combinational RV32 integer ALU; unknown opcodes produce zero.
module alu
  import alu_arbiter_pkg::*;
(
  input  logic [ALU_OPCODE_WIDTH-1:0] op,
  input  logic [XPR_LEN-1:0]          in1,
  input  logic [XPR_LEN-1:0]          in2,
  output logic [XPR_LEN-1:0]          out
);

  logic signed [XPR_LEN-1:0] in1_s;
  logic signed [XPR_LEN-1:0] in2_s;
  logic [SHAMT_WIDTH-1:0]    shamt;

  assign in1_s = $signed(in1);
  assign in2_s = $signed(in2);
  assign shamt = in2[SHAMT_WIDTH-1:0];

  always_comb begin
    out = '0;
    case (op)
      ALU_OP_ADD:  out = in1 + in2;
      ALU_OP_SLL:  out = in1 << shamt;
      ALU_OP_XOR:  out = in1 ^ in2;
      ALU_OP_OR:   out = in1 | in2;
      ALU_OP_AND:  out = in1 & in2;
      ALU_OP_SRL:  out = in1 >> shamt;
      ALU_OP_SEQ:  out = {{(XPR_LEN-1){1'b0}}, in1 == in2};
      ALU_OP_SNE:  out = {{(XPR_LEN-1){1'b0}}, in1 != in2};
      ALU_OP_SUB:  out = in1 - in2;
      ALU_OP_SRA:  out = $unsigned(in1_s >>> shamt);
      ALU_OP_SLT:  out = {{(XPR_LEN-1){1'b0}}, in1_s < in2_s};
      ALU_OP_SGE:  out = {{(XPR_LEN-1){1'b0}}, in1_s >= in2_s};
      ALU_OP_SLTU: out = {{(XPR_LEN-1){1'b0}}, in1 < in2};
      ALU_OP_SGEU: out = {{(XPR_LEN-1){1'b0}}, in1 >= in2};
      default:     out = '0;
    endcase
  end

endmodule

// File: rtl/alu_rr_picker.sv
// Combinational round-robin picker: first valid bit at or after ptr, wrapping.
module alu_rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any_gnt
);

  function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base, input int k);
    return ID_W'((int'(base) + k) % NUM_REQ);
  endfunction

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any_gnt = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_gnt && valid[rr_index(ptr, k)]) begin
        any_gnt                = 1'b1;
        gnt_idx                = rr_index(ptr, k);
        gnt[rr_index(ptr, k)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQ requesters, with a single
// registered, owner-tagged result slot that can drain and refill each cycle.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ*ALU_OPCODE_WIDTH-1:0] req_opcode,
  input  logic [NUM_REQ*XPR_LEN-1:0]          req_in1,
  input  logic [NUM_REQ*XPR_LEN-1:0]          req_in2,
  output logic [NUM_REQ-1:0]                  resp_valid,
  input  logic [NUM_REQ-1:0]                  resp_ready,
  output logic [XPR_LEN-1:0]                  resp_data,
  output logic [ID_W-1:0]                     resp_id,
  output logic                                busy
);

  slot_state_t          state_q, state_d;
  logic [ID_W-1:0]      ptr_q;
  logic [XPR_LEN-1:0]   data_p1;
  logic [ID_W-1:0]      id_p1;

  logic [NUM_REQ-1:0]          gnt;
  logic [ID_W-1:0]             gnt_idx;
  logic                        any_gnt;
  logic                        can_accept;
  logic                        accept;
  logic                        drain;
  logic [ALU_OPCODE_WIDTH-1:0] alu_op;
  logic [XPR_LEN-1:0]          alu_a;
  logic [XPR_LEN-1:0]          alu_b;
  logic [XPR_LEN-1:0]          alu_out;

  alu_rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_picker (
    .valid   (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_gnt (any_gnt)
  );

  assign alu_op = req_opcode[gnt_idx*ALU_OPCODE_WIDTH +: ALU_OPCODE_WIDTH];
  assign alu_a  = req_in1[gnt_idx*XPR_LEN +: XPR_LEN];
  assign alu_b  = req_in2[gnt_idx*XPR_LEN +: XPR_LEN];

  alu u_alu (
    .op  (alu_op),
    .in1 (alu_a),
    .in2 (alu_b),
    .out (alu_out)
  );

  // A non-owner's resp_ready never reaches the slot: only the owner bit is looked at.
  assign drain      = (state_q == SLOT_FULL) && resp_ready[id_p1];
  assign can_accept = (state_q == SLOT_EMPTY) || drain;
  assign req_ready  = (any_gnt && can_accept) ? gnt : '0;
  assign accept     = |(req_valid & req_ready);

  always_comb begin
    state_d = state_q;
    if (accept)     state_d = SLOT_FULL;
    else if (drain) state_d = SLOT_EMPTY;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= SLOT_EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) ptr_q <= ID_W'((int'(gnt_idx) + 1) % NUM_REQ);
    end
  end

  // Stage p1: registered ALU result and owner tag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_p1 <= '0;
      id_p1   <= '0;
    end else if (accept) begin
      data_p1 <= alu_out;
      id_p1   <= gnt_idx;
    end
  end

  always_comb begin
    resp_valid = '0;
    if (state_q == SLOT_FULL) resp_valid[id_p1] = 1'b1;
  end

  assign resp_data = data_p1;
  assign resp_id   = id_p1;
  assign busy      = (state_q == SLOT_FULL);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with two requesters and hand-computed results.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic                                clk = 1'b0;
  logic                                reset_n;
  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0]                  req_ready;
  logic [NUM_REQ*ALU_OPCODE_WIDTH-1:0] req_opcode;
  logic [NUM_REQ*XPR_LEN-1:0]          req_in1;
  logic [NUM_REQ*XPR_LEN-1:0]          req_in2;
  logic [NUM_REQ-1:0]                  resp_valid;
  logic [NUM_REQ-1:0]                  resp_ready;
  logic [XPR_LEN-1:0]                  resp_data;
  logic [ID_W-1:0]                     resp_id;
  logic                                busy;

  int errors = 0;
  int checks = 0;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opcode (req_opcode),
    .req_in1    (req_in1),
    .req_in2    (req_in2),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]                 = v;
    req_opcode[i*4 +: 4]         = op;
    req_in1[i*32 +: 32]          = a;
    req_in2[i*32 +: 32]          = b;
  endtask

  logic [3:0]  sweep_op  [15];
  logic [31:0] sweep_exp [15];

  initial begin
    sweep_op[0]  = ALU_OP_ADD;  sweep_exp[0]  = 32'h0000_0020;
    sweep_op[1]  = ALU_OP_SLL;  sweep_exp[1]  = 32'hFFFF_FFFE;
    sweep_op[2]  = ALU_OP_XOR;  sweep_exp[2]  = 32'hFFFF_FFDE;
    sweep_op[3]  = ALU_OP_OR;   sweep_exp[3]  = 32'hFFFF_FFFF;
    sweep_op[4]  = ALU_OP_AND;  sweep_exp[4]  = 32'h0000_0021;
    sweep_op[5]  = ALU_OP_SRL;  sweep_exp[5]  = 32'h7FFF_FFFF;
    sweep_op[6]  = ALU_OP_SEQ;  sweep_exp[6]  = 32'h0000_0000;
    sweep_op[7]  = ALU_OP_SNE;  sweep_exp[7]  = 32'h0000_0001;
    sweep_op[8]  = ALU_OP_SUB;  sweep_exp[8]  = 32'hFFFF_FFDE;
    sweep_op[9]  = ALU_OP_SRA;  sweep_exp[9]  = 32'hFFFF_FFFF;
    sweep_op[10] = ALU_OP_SLT;  sweep_exp[10] = 32'h0000_0001;
    sweep_op[11] = ALU_OP_SGE;  sweep_exp[11] = 32'h0000_0000;
    sweep_op[12] = ALU_OP_SLTU; sweep_exp[12] = 32'h0000_0000;
    sweep_op[13] = ALU_OP_SGEU; sweep_exp[13] = 32'h0000_0001;
    sweep_op[14] = 4'd14;       sweep_exp[14] = 32'h0000_0000;

    reset_n    = 1'b0;
    req_valid  = '0;
    req_opcode = '0;
    req_in1    = '0;
    req_in2    = '0;
    resp_ready = 2'b11;

    // Reset and basic ADD
    step();
    step();
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    check("rst_resp_data",  resp_data,       32'h0);
    check("rst_resp_id",    32'(resp_id),    32'h0);
    reset_n = 1'b1;
    set_req(0, 1'b1, ALU_OP_ADD, 32'd5, 32'd7);
    settle();
    check("add_req_ready", 32'(req_ready), 32'h1);
    step();
    set_req(0, 1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    check("add_resp_valid", 32'(resp_valid), 32'h1);
    check("add_resp_data",  resp_data,       32'd12);
    check("add_resp_id",    32'(resp_id),    32'h0);
    check("add_busy",       32'(busy),       32'h1);
    step();
    check("add_drained", 32'(busy), 32'h0);

    // Bring pointer back to 0 with a lone req1 grant
    set_req(1, 1'b1, ALU_OP_ADD, 32'd1, 32'd1);
    settle();
    check("r1_req_ready", 32'(req_ready), 32'h2);
    step();
    set_req(1, 1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    check("r1_resp_data", resp_data, 32'd2);
    step();

    // Contention with full throughput
    set_req(0, 1'b1, ALU_OP_SUB, 32'd3, 32'd5);
    set_req(1, 1'b1, ALU_OP_SLT, 32'hFFFF_FFFF, 32'd0);
    for (int i = 0; i < 4; i++) begin
      settle();
      check($sformatf("cont_grant%0d", i), 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
      step();
      check($sformatf("cont_id%0d", i), 32'(resp_id), 32'(i % 2));
      check($sformatf("cont_data%0d", i), resp_data, (i % 2 == 0) ? 32'hFFFF_FFFE : 32'h1);
    end
    req_valid = '0;
    step();
    check("cont_drained", 32'(busy), 32'h0);

    // Backpressure on requester 1
    set_req(1, 1'b1, ALU_OP_SRA, 32'h8000_0000, 32'd4);
    settle();
    check("bp_grant1", 32'(req_ready), 32'h2);
    step();
    set_req(1, 1'b0, ALU_OP_SRA, 32'd0, 32'd0);
    set_req(0, 1'b1, ALU_OP_ADD, 32'd2, 32'd3);
    resp_ready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      settle();
      check($sformatf("bp_ready%0d", i), 32'(req_ready), 32'h0);
      check($sformatf("bp_data%0d", i), resp_data, 32'hF800_0000);
      check($sformatf("bp_valid%0d", i), 32'(resp_valid), 32'h2);
      step();
    end
    resp_ready = 2'b11;
    settle();
    check("bp_release_ready", 32'(req_ready), 32'h1);
    step();
    set_req(0, 1'b0, ALU_OP_ADD, 32'd0, 32'd0);
    check("bp_next_id",    32'(resp_id),    32'h0);
    check("bp_next_data",  resp_data,       32'd5);
    check("bp_next_valid", 32'(resp_valid), 32'h1);
    step();

    // Idle cycles do not rotate priority
    set_req(1, 1'b1, ALU_OP_ADD, 32'd10, 32'd20);
    settle();
    check("idle_grant1", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    step();
    step();
    step();
    set_req(0, 1'b1, ALU_OP_ADD, 32'd1, 32'd2);
    set_req(1, 1'b1, ALU_OP_ADD, 32'd10, 32'd20);
    settle();
    check("idle_first_grant", 32'(req_ready), 32'h1);
    step();
    check("idle_data", resp_data, 32'd3);

    // Reset while the slot holds a requester-1 result
    req_valid[0] = 1'b0;
    settle();
    check("mid_grant1", 32'(req_ready), 32'h2);
    step();
    req_valid  = '0;
    resp_ready = 2'b00;
    check("mid_full_valid", 32'(resp_valid), 32'h2);
    check("mid_full_id",    32'(resp_id),    32'h1);
    reset_n = 1'b0;
    step();
    check("mid_rst_valid", 32'(resp_valid), 32'h0);
    check("mid_rst_busy",  32'(busy),       32'h0);
    check("mid_rst_data",  resp_data,       32'h0);
    reset_n    = 1'b1;
    resp_ready = 2'b11;
    set_req(0, 1'b1, ALU_OP_ADD, 32'd4, 32'd4);
    set_req(1, 1'b1, ALU_OP_ADD, 32'd6, 32'd6);
    settle();
    check("mid_after_grant", 32'(req_ready), 32'h1);
    step();
    req_valid = '0;
    check("mid_after_data", resp_data, 32'd8);
    step();

    // Opcode sweep, back-to-back on requester 0
    for (int i = 0; i < 15; i++) begin
      set_req(0, 1'b1, sweep_op[i], 32'hFFFF_FFFF, 32'h0000_0021);
      settle();
      check($sformatf("sweep_ready%0d", i), 32'(req_ready), 32'h1);
      step();
      check($sformatf("sweep_op%0d", i), resp_data, sweep_exp[i]);
    end
    req_valid = '0;
    step();
    check("final_idle", 32'(busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
